bird_physics: RTL and testbench
===============================

Name: bird_physics

Overview:
- Parametrised successor to the fixed-step bird height controller.
- Models the bird with signed velocity, gravity, flap impulse, terminal fall speed, ceiling clamp and floor-crash detection.
- Steps once per frame `tick` and runs a small game-state FSM (IDLE/FLYING/DEAD).
- Feeds the renderer (`height`) and the collision/score logic (`crashed`, `state`).

Parameters:
- H_W, 9, height width in bits (unsigned).
- V_W, 6, velocity width in bits (two's-complement signed).
- DEFAULT_H, 240, height loaded on reset and on restart.
- MIN_H, 0, floor height; reaching or passing it is a crash.
- MAX_H, 479, ceiling height; clamped, not fatal.
- GRAVITY, 1, velocity decrement per tick.
- FLAP_V, 8, velocity loaded on a flap (positive = up).
- MAX_FALL, 12, terminal fall speed magnitude (velocity floor is -MAX_FALL).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- tick, in, 1, one-cycle frame-step strobe.
- start, in, 1, begin game (IDLE), restart (DEAD).
- flap, in, 1, raw level from button; edge-detected internally.
- height, out, H_W, current height, unsigned.
- velocity, out, V_W, current signed velocity.
- state, out, 2, 0=IDLE, 1=FLYING, 2=DEAD (3 unused).
- crashed, out, 1, high while in DEAD.

Behaviour:
- Reset: reset is synchronous and active-high; the clock is clk. Reset dominates every other input in the same cycle.
  - Outputs after reset: height=DEFAULT_H, velocity=0, state=IDLE, crashed=0.
  - Internal state cleared: flap_q=0, flap_pend=0.
- Flap edge: flap_q registers `flap` every cycle. A rise is `flap & ~flap_q`.
  - In FLYING, a rise sets flap_pend.
  - flap_pend clears on the next tick.
  - Multiple rises between ticks count as one.
  - A rise in the same cycle as tick is consumed by that tick.
  - Rises in IDLE and DEAD are ignored; they are not latched.
- IDLE:
  - Outputs held at reset values; tick is ignored.
  - start=1 moves to FLYING on the next edge; height and velocity are unchanged.
- FLYING, on tick (all updates visible the cycle after the tick):
  - v_next = FLAP_V if a flap is pending or arriving; otherwise max(velocity - GRAVITY, -MAX_FALL).
  - h_next = height + sign-extended v_next, computed in H_W+2-bit signed arithmetic so it never wraps.
  - If h_next <= MIN_H: height=MIN_H, velocity=0, state=DEAD, crashed=1.
  - Else if h_next > MAX_H: height=MAX_H, velocity=0, state stays FLYING.
  - Else: height=h_next, velocity=v_next.
- FLYING with no tick: all outputs are held; start is ignored.
- DEAD: outputs held, crashed=1, tick ignored. start=1 on the next edge restores the reset values (height=DEFAULT_H, velocity=0, state=IDLE, crashed=0).
- Exactly one register update per tick; there is no combinational path from inputs to outputs.
- Parameter legality: MIN_H < DEFAULT_H < MAX_H < 2^H_W; FLAP_V and MAX_FALL fit in V_W signed. Violations are flagged by an elaboration-time assertion.

Test Plan:
- Reset then 3 ticks without start → height=240, velocity=0, state=0, crashed=0 throughout.
- start, then 3 ticks with no flap → velocity -1,-2,-3 and height 239,237,234; state=1.
- From height=234 / velocity=-3: pulse flap for 2 cycles (one rise), then 2 ticks → first tick gives velocity=8, height=242; second gives velocity=7, height=249. A second rise before the first tick gives the same result.
- Free fall from 240 → velocity saturates at -12 and stays there; height reaches 0, state=2, crashed=1. Further ticks and flaps change nothing. start → height=240, velocity=0, state=0.
- Repeated flap/tick pairs near the ceiling → height clamps to 479 with velocity=0, state stays 1. The next tick with no flap gives velocity=-1, height=478.
- Simultaneous events:
  - reset and tick in the same FLYING cycle → reset values.
  - flap rise while in IDLE, then start, then tick → no flap is applied: velocity=-1, height=239.

Source files
------------

// File: rtl/bird_physics.sv
// bird_physics: per-frame bird kinematics (signed velocity, gravity, flap
// impulse, terminal fall speed, ceiling clamp) with an IDLE/FLYING/DEAD game
// state. Every output comes straight from a register, so no input reaches an
// output in the same cycle.
module bird_physics #(
    parameter int H_W       = 9,
    parameter int V_W       = 6,
    parameter int DEFAULT_H = 240,
    parameter int MIN_H     = 0,
    parameter int MAX_H     = 479,
    parameter int GRAVITY   = 1,
    parameter int FLAP_V    = 8,
    parameter int MAX_FALL  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  flap,
    output logic [H_W-1:0]        height,
    output logic signed [V_W-1:0] velocity,
    output logic [1:0]            state,
    output logic                  crashed
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLYING = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    // Reject parameter sets that would make the arithmetic below wrap.
    if (!(MIN_H >= 0 && MIN_H < DEFAULT_H && DEFAULT_H < MAX_H &&
          MAX_H < (1 << H_W))) begin : g_bad_heights
        $error("bird_physics: need 0 <= MIN_H < DEFAULT_H < MAX_H < 2**H_W");
    end
    if (!(FLAP_V >= 0 && FLAP_V <= (1 << (V_W - 1)) - 1 &&
          MAX_FALL >= 0 && MAX_FALL <= (1 << (V_W - 1)) &&
          GRAVITY >= 0 && GRAVITY <= (1 << (V_W - 1)))) begin : g_bad_velocity
        $error("bird_physics: FLAP_V, MAX_FALL and GRAVITY must fit in V_W signed");
    end
    if (!(V_W < H_W + 2)) begin : g_bad_widths
        $error("bird_physics: V_W must be narrower than H_W+2");
    end

    localparam int NEG_MAX_FALL = -MAX_FALL;

    localparam logic [H_W-1:0]        DEFAULT_HV = DEFAULT_H[H_W-1:0];
    localparam logic [H_W-1:0]        MIN_HV     = MIN_H[H_W-1:0];
    localparam logic [H_W-1:0]        MAX_HV     = MAX_H[H_W-1:0];
    // Height bounds widened to the signed H_W+2 domain used for h_next.
    localparam logic signed [H_W+1:0] MIN_HE     = MIN_H[H_W+1:0];
    localparam logic signed [H_W+1:0] MAX_HE     = MAX_H[H_W+1:0];
    // Velocity constants; the V_W+1 forms hold velocity - GRAVITY without wrap.
    localparam logic signed [V_W:0]   GRAV_E     = GRAVITY[V_W:0];
    localparam logic signed [V_W:0]   FLOOR_VE   = NEG_MAX_FALL[V_W:0];
    localparam logic signed [V_W-1:0] FLOOR_VV   = NEG_MAX_FALL[V_W-1:0];
    localparam logic signed [V_W-1:0] FLAP_VV    = FLAP_V[V_W-1:0];

    state_t                  state_q, state_d;
    logic [H_W-1:0]          height_q, height_d;
    logic signed [V_W-1:0]   velocity_q, velocity_d;
    logic                    flap_q;
    logic                    pend_q, pend_d;

    logic                    flap_rise;
    logic signed [V_W:0]     v_dec;
    logic signed [V_W-1:0]   v_fall;
    logic signed [V_W-1:0]   v_next;
    logic signed [H_W+1:0]   h_sum;

    // Register all state; reset restores the start-of-game values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            height_q   <= DEFAULT_HV;
            velocity_q <= '0;
            flap_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            height_q   <= height_d;
            velocity_q <= velocity_d;
            flap_q     <= flap;
            pend_q     <= pend_d;
        end
    end

    // Next-state logic: flap edge bookkeeping, kinematics on tick, game FSM.
    always_comb begin
        state_d    = state_q;
        height_d   = height_q;
        velocity_d = velocity_q;
        pend_d     = pend_q;

        flap_rise = flap & ~flap_q;

        // Gravity with terminal-speed floor, unless a flap overrides it.
        v_dec  = $signed({velocity_q[V_W-1], velocity_q}) - GRAV_E;
        v_fall = (v_dec < FLOOR_VE) ? FLOOR_VV : v_dec[V_W-1:0];
        v_next = (pend_q | flap_rise) ? FLAP_VV : v_fall;

        // Two guard bits keep the candidate height from wrapping either way.
        h_sum = $signed({2'b00, height_q}) +
                $signed({{(H_W + 2 - V_W){v_next[V_W-1]}}, v_next});

        unique case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (start) begin
                    state_d = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (tick) begin
                    // The tick consumes any pending flap and any rise this cycle.
                    pend_d = 1'b0;
                    if (h_sum <= MIN_HE) begin
                        height_d   = MIN_HV;
                        velocity_d = '0;
                        state_d    = ST_DEAD;
                    end else if (h_sum > MAX_HE) begin
                        height_d   = MAX_HV;
                        velocity_d = '0;
                    end else begin
                        height_d   = h_sum[H_W-1:0];
                        velocity_d = v_next;
                    end
                end else if (flap_rise) begin
                    pend_d = 1'b1;
                end
            end
            ST_DEAD: begin
                pend_d = 1'b0;
                if (start) begin
                    state_d    = ST_IDLE;
                    height_d   = DEFAULT_HV;
                    velocity_d = '0;
                end
            end
            default: begin
                // Unused encoding: fall back to a clean idle game.
                state_d    = ST_IDLE;
                height_d   = DEFAULT_HV;
                velocity_d = '0;
                pend_d     = 1'b0;
            end
        endcase
    end

    assign height   = height_q;
    assign velocity = velocity_q;
    assign state    = state_q;
    assign crashed  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed plan scenarios followed by random play, checked
// every cycle against an integer-arithmetic model of the bird rules.
module tb_bird_physics;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic              start;
    logic              flap;
    logic [8:0]        height;
    logic signed [5:0] velocity;
    logic [1:0]        state;
    logic              crashed;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (plain integers; state 0=IDLE 1=FLYING 2=DEAD).
    int m_h, m_v, m_st, m_fq, m_pend;

    bird_physics dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .flap     (flap),
        .height   (height),
        .velocity (velocity),
        .state    (state),
        .crashed  (crashed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply the game rules to the model for one clock edge.
    task automatic model_step();
        int rise, vn, hn;
        if (reset) begin
            m_h = 240; m_v = 0; m_st = 0; m_fq = 0; m_pend = 0;
            return;
        end
        rise = (flap && m_fq == 0) ? 1 : 0;
        case (m_st)
            0: begin
                m_pend = 0;
                if (start) m_st = 1;
            end
            1: begin
                if (tick) begin
                    if (m_pend || rise) vn = 8;
                    else vn = (m_v - 1 < -12) ? -12 : m_v - 1;
                    hn = m_h + vn;
                    if (hn <= 0) begin
                        m_h = 0; m_v = 0; m_st = 2;
                    end else if (hn > 479) begin
                        m_h = 479; m_v = 0;
                    end else begin
                        m_h = hn; m_v = vn;
                    end
                    m_pend = 0;
                end else if (rise) begin
                    m_pend = 1;
                end
            end
            default: begin
                m_pend = 0;
                if (start) begin
                    m_h = 240; m_v = 0; m_st = 0;
                end
            end
        endcase
        m_fq = flap ? 1 : 0;
    endtask

    // One clock: drive inputs, step the model at the edge, compare just after.
    task automatic cyc(input logic r, input logic t, input logic s, input logic f);
        reset = r; tick = t; start = s; flap = f;
        @(posedge clk);
        model_step();
        #1;
        chk("height",   int'(height),   m_h);
        chk("velocity", int'(velocity), m_v);
        chk("state",    int'(state),    m_st);
        chk("crashed",  int'(crashed),  (m_st == 2) ? 1 : 0);
    endtask

    // Hand-derived checkpoint values from the scenario descriptions.
    task automatic expect_hvs(input string tag, input int h, input int v, input int st);
        chk({tag, "_h"},  int'(height),   h);
        chk({tag, "_v"},  int'(velocity), v);
        chk({tag, "_st"}, int'(state),    st);
        chk({tag, "_cr"}, int'(crashed),  (st == 2) ? 1 : 0);
    endtask

    initial begin
        logic r, t, s, f;
        reset = 1'b1; tick = 1'b0; start = 1'b0; flap = 1'b0;
        m_h = 240; m_v = 0; m_st = 0; m_fq = 0; m_pend = 0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        expect_hvs("reset", 240, 0, 0);

        // IDLE ignores ticks.
        repeat (3) cyc(0, 1, 0, 0);
        expect_hvs("idle_tick", 240, 0, 0);

        // Start, then free fall for three ticks.
        cyc(0, 0, 1, 0);
        expect_hvs("start", 240, 0, 1);
        cyc(0, 1, 0, 0);
        expect_hvs("fall1", 239, -1, 1);
        cyc(0, 0, 0, 0);
        expect_hvs("hold", 239, -1, 1);
        cyc(0, 1, 0, 0);
        expect_hvs("fall2", 237, -2, 1);
        cyc(0, 1, 0, 0);
        expect_hvs("fall3", 234, -3, 1);

        // Two-cycle flap pulse is one rise, applied by the next tick.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        expect_hvs("flap1", 242, 8, 1);
        cyc(0, 1, 0, 0);
        expect_hvs("flap2", 249, 7, 1);

        // Two rises before one tick count once.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        expect_hvs("dbl_rise", 257, 8, 1);

        // Reset wins over a simultaneous tick in FLYING.
        cyc(1, 1, 0, 0);
        expect_hvs("rst_tick", 240, 0, 0);

        // Free fall from 240 to the floor with terminal speed.
        cyc(0, 0, 1, 0);
        repeat (13) cyc(0, 1, 0, 0);
        expect_hvs("terminal", 150, -12, 1);
        cyc(0, 1, 0, 0);
        expect_hvs("terminal2", 138, -12, 1);
        repeat (30) cyc(0, 1, 0, 0);
        expect_hvs("crash", 0, 0, 2);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 1);
        expect_hvs("dead_hold", 0, 0, 2);
        cyc(0, 0, 1, 0);
        expect_hvs("restart", 240, 0, 0);

        // Flap every tick until the ceiling clamps.
        cyc(0, 0, 1, 0);
        repeat (35) begin
            cyc(0, 1, 0, 1);
            cyc(0, 0, 0, 0);
        end
        expect_hvs("ceiling", 479, 0, 1);
        cyc(0, 1, 0, 0);
        expect_hvs("ceil_fall", 478, -1, 1);

        // A rise seen in IDLE is not carried into the game.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 1);
        expect_hvs("idle_rise", 239, -1, 1);
        cyc(0, 0, 0, 0);

        // Random play against the model.
        f = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, (i < 750) ? 4 : 12) == 0) f = ~f;
            cyc(r, t, s, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
